// File: rtl/audio_rom_sync_if.sv
// Lookup bus between the wave generator (master) and the audio ROM (slave).
// The generator drives index/freq_id and consumes level, freq and period.
interface audio_rom_sync_if #(
  parameter int BITS = 6
);
  logic [9:0]      index;
  logic [4:0]      freq_id;
  logic [BITS-1:0] level;
  logic [15:0]     freq;
  logic [15:0]     period;

  modport master (
    output index,
    output freq_id,
    input  level,
    input  freq,
    input  period
  );

  modport slave (
    input  index,
    input  freq_id,
    output level,
    output freq,
    output period
  );
endinterface

// File: rtl/audio_rom_sync.sv
// Registered note/sine lookup: 5-bit note ID -> period/phase increment,
// 10-bit phase index -> unsigned sine level of BITS bits. One clock of latency.
module audio_rom_sync #(
  parameter int BITS = 6
) (
  input  logic            clock,
  input  logic            reset,
  audio_rom_sync_if.slave bus
);

  localparam int              AMP     = (1 << (BITS - 1)) - 1;
  localparam logic [BITS-1:0] AMP_V   = BITS'(AMP);
  localparam int              FRAC    = 28;
  localparam longint          PI_Q    = 64'sd843314857;

  // Fixed-point (Q28) value to nearest integer, ties upward.
  function automatic longint round_q(input longint val_q);
    return (val_q + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
  endfunction

  // Integer quotient rounded half-up.
  function automatic int round_div(input int num, input int den);
    return (2 * num + den) / (2 * den);
  endfunction

  // q[k] = round(AMP * sin(2*pi*k/1024)) via a Q28 Taylor series; the
  // series is carried to x^17 so the error stays far below one output LSB.
  function automatic int quarter_sine(input int k);
    longint x;
    longint x2;
    longint term;
    longint sum;
    x    = (PI_Q * longint'(k) + 64'sd256) / 64'sd512;
    x2   = (x * x) >>> FRAC;
    term = x;
    sum  = x;
    for (int n = 1; n <= 8; n++) begin
      term = -((term * x2) >>> FRAC) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return int'(round_q(longint'(AMP) * sum));
  endfunction

  // round(243 * 2^((12-id)/12)); ID 12 is middle C, ID 24 is the 121.5 tie.
  function automatic int note_period(input int id);
    case (id)
      0:       return 486;
      1:       return 459;
      2:       return 433;
      3:       return 409;
      4:       return 386;
      5:       return 364;
      6:       return 344;
      7:       return 324;
      8:       return 306;
      9:       return 289;
      10:      return 273;
      11:      return 257;
      12:      return 243;
      13:      return 229;
      14:      return 216;
      15:      return 204;
      16:      return 193;
      17:      return 182;
      18:      return 172;
      19:      return 162;
      20:      return 153;
      21:      return 144;
      22:      return 136;
      23:      return 129;
      24:      return 122;
      25:      return 115;
      26:      return 108;
      27:      return 102;
      28:      return 96;
      29:      return 91;
      30:      return 86;
      default: return 81;
    endcase
  endfunction

  logic [15:0]     w_period_tab [32];
  logic [15:0]     w_freq_tab   [32];
  logic [BITS-2:0] w_qtab       [257];

  for (genvar g = 0; g < 32; g++) begin : g_note
    localparam int P = note_period(g);
    assign w_period_tab[g] = 16'(P);
    assign w_freq_tab[g]   = 16'(round_div(65536, P));
  end

  for (genvar g = 0; g <= 256; g++) begin : g_sine
    localparam int Q = quarter_sine(g);
    assign w_qtab[g] = (BITS - 1)'(Q);
  end

  // Stage p0: fold the phase index onto the quarter table.
  // No q entry is an exact half, so AMP - q equals the half-up rounding of
  // the negative half-cycle and the two halves stay mirror images.
  logic [8:0]      w_qaddr_p0;
  logic [BITS-2:0] w_q_p0;
  logic [BITS-1:0] w_level_p0;

  always_comb begin
    w_qaddr_p0 = {1'b0, bus.index[7:0]};
    if (bus.index[8]) begin
      w_qaddr_p0 = 9'd256 - {1'b0, bus.index[7:0]};
    end
    w_q_p0     = w_qtab[w_qaddr_p0];
    w_level_p0 = bus.index[9] ? (AMP_V - {1'b0, w_q_p0})
                              : (AMP_V + {1'b0, w_q_p0});
  end

  // Stage p1: registered outputs.
  logic [BITS-1:0] r_level_p1;
  logic [15:0]     r_freq_p1;
  logic [15:0]     r_period_p1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_level_p1  <= '0;
      r_freq_p1   <= '0;
      r_period_p1 <= '0;
    end else begin
      r_level_p1  <= w_level_p0;
      r_freq_p1   <= w_freq_tab[bus.freq_id];
      r_period_p1 <= w_period_tab[bus.freq_id];
    end
  end

  assign bus.level  = r_level_p1;
  assign bus.freq   = r_freq_p1;
  assign bus.period = r_period_p1;

endmodule

// File: tb/tb_audio_rom_sync.sv
// Directed + randomized bench for audio_rom_sync (BITS=6 and BITS=8 side by
// side) against a real-arithmetic reference model of the lookup formulas.
module tb_audio_rom_sync;

  localparam real PI = 3.14159265358979323846;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  audio_rom_sync_if #(.BITS(6)) bus6 ();
  audio_rom_sync_if #(.BITS(8)) bus8 ();

  audio_rom_sync #(.BITS(6)) u_dut6 (
    .clock (clock),
    .reset (reset),
    .bus   (bus6)
  );

  audio_rom_sync #(.BITS(8)) u_dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (bus8)
  );

  function automatic int m_level(input int bits, input int i);
    int  a;
    real r;
    a = (1 << (bits - 1)) - 1;
    r = a * (1.0 + $sin(2.0 * PI * i / 1024.0));
    return int'($floor(r + 0.5));
  endfunction

  function automatic int m_period(input int id);
    return int'($floor(243.0 * $pow(2.0, (12.0 - id) / 12.0) + 0.5));
  endfunction

  function automatic int m_freq(input int id);
    return int'($floor(65536.0 / m_period(id) + 0.5));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int idx, input int fid);
    bus6.index   = 10'(idx);
    bus6.freq_id = 5'(fid);
    bus8.index   = 10'(idx);
    bus8.freq_id = 5'(fid);
  endtask

  task automatic check_outputs(input string tag, input int idx, input int fid);
    chk({tag, ".level6"},  32'(bus6.level),  m_level(6, idx));
    chk({tag, ".level8"},  32'(bus8.level),  m_level(8, idx));
    chk({tag, ".freq"},    32'(bus6.freq),   m_freq(fid));
    chk({tag, ".period"},  32'(bus6.period), m_period(fid));
    chk({tag, ".freq8"},   32'(bus8.freq),   m_freq(fid));
    chk({tag, ".period8"}, 32'(bus8.period), m_period(fid));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".level6"}, 32'(bus6.level),  0);
    chk({tag, ".level8"}, 32'(bus8.level),  0);
    chk({tag, ".freq"},   32'(bus6.freq),   0);
    chk({tag, ".period"}, 32'(bus6.period), 0);
  endtask

  task automatic step_check(input string tag, input int idx, input int fid);
    drive(idx, fid);
    @(posedge clock);
    #1;
    check_outputs(tag, idx, fid);
  endtask

  int lv6 [1024];
  int lv8 [1024];
  int per [32];
  int frq [32];
  int card_idx [4] = '{0, 256, 512, 768};
  int card_l6  [4] = '{31, 62, 31, 0};
  int card_l8  [4] = '{127, 254, 127, 0};

  initial begin
    int prev_p;
    int diff;
    int cur_i;
    int cur_f;
    int nxt_i;
    int nxt_f;

    // Power-up reset
    reset = 1'b0;
    drive(0, 0);
    #2;
    check_zero("por_async");
    @(posedge clock);
    #1;
    check_zero("por_held");
    @(negedge clock);
    reset = 1'b1;
    step_check("first", 0, 12);

    // Cardinal points
    for (int c = 0; c < 4; c++) begin
      step_check("card", card_idx[c], int'($urandom_range(0, 31)));
      chk("card.l6", 32'(bus6.level), card_l6[c]);
      chk("card.l8", 32'(bus8.level), card_l8[c]);
    end

    // Note table sweep
    prev_p = 100000;
    for (int id = 0; id < 32; id++) begin
      step_check("note", int'($urandom_range(0, 1023)), id);
      per[id] = int'(bus6.period);
      frq[id] = int'(bus6.freq);
      chk("note.decreasing", 32'(per[id] < prev_p), 1);
      diff = per[id] * frq[id] - 65536;
      if (diff < 0) diff = -diff;
      chk("note.product", 32'(diff * 100 <= 65536), 1);
      prev_p = per[id];
    end
    chk("note0.period", per[0], 486);
    chk("note0.freq", frq[0], 135);
    chk("note12.period", per[12], 243);
    chk("note12.freq", frq[12], 270);
    chk("note24.period", per[24], 122);
    chk("note24.freq", frq[24], 537);
    chk("note31.period", per[31], 81);
    chk("note31.freq", frq[31], 809);

    // Full phase sweep
    for (int i = 0; i < 1024; i++) begin
      step_check("sweep", i, int'($urandom_range(0, 31)));
      lv6[i] = int'(bus6.level);
      lv8[i] = int'(bus8.level);
    end
    for (int i = 0; i < 512; i++) begin
      chk("sym.half6", lv6[i] + lv6[i + 512], 62);
      chk("sym.half8", lv8[i] + lv8[i + 512], 254);
    end
    for (int k = 1; k < 256; k++) begin
      chk("sym.mirror6", lv6[256 - k], lv6[256 + k]);
    end
    for (int i = 0; i < 1024; i++) begin
      chk("sym.max6", 32'(lv6[i] <= 62), 1);
      diff = lv6[(i + 1) % 1024] - lv6[i];
      if (diff < 0) diff = -diff;
      chk("sym.step6", 32'(diff <= 1), 1);
    end

    // Latency and independence
    cur_i = 100;
    cur_f = 3;
    step_check("lat.base", cur_i, cur_f);
    for (int t = 0; t < 8; t++) begin
      nxt_i = (cur_i + 1 + int'($urandom_range(0, 1022))) % 1024;
      nxt_f = (cur_f + 1 + int'($urandom_range(0, 30))) % 32;
      drive(nxt_i, nxt_f);
      #3;
      check_outputs("lat.before", cur_i, cur_f);
      @(posedge clock);
      #1;
      check_outputs("lat.after", nxt_i, nxt_f);
      for (int h = 0; h < 3; h++) begin
        @(posedge clock);
        #1;
        check_outputs("lat.hold", nxt_i, nxt_f);
      end
      cur_i = nxt_i;
      cur_f = nxt_f;
    end

    // Reset mid-operation
    step_check("midrst.pre", 256, 12);
    #2;
    reset = 1'b0;
    #1;
    check_zero("midrst.async");
    drive(300, 5);
    @(posedge clock);
    #1;
    check_zero("midrst.held");
    @(negedge clock);
    reset = 1'b1;
    drive(256, 12);
    @(posedge clock);
    #1;
    chk("midrst.level6", 32'(bus6.level), 62);
    chk("midrst.level8", 32'(bus8.level), 254);
    chk("midrst.freq", 32'(bus6.freq), 270);
    chk("midrst.period", 32'(bus6.period), 243);

    // BITS=8 variant points
    step_check("b8", 256, 0);
    chk("b8.256", 32'(bus8.level), 254);
    step_check("b8", 768, 31);
    chk("b8.768", 32'(bus8.level), 0);
    step_check("b8", 0, 24);
    chk("b8.0", 32'(bus8.level), 127);

    // Random traffic
    for (int r = 0; r < 300; r++) begin
      step_check("rand", int'($urandom_range(0, 1023)), int'($urandom_range(0, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
